// File: rtl/rgb_pwm_driver.sv
// Three-channel active-low LED PWM driver with a one-word colour buffer.
// New duties take effect only at period boundaries, so a period is never split.
module rgb_pwm_driver #(
  parameter int PRESCALE = 47
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic       period_start,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic [7:0]    pwm_cnt;
  logic [7:0]    duty_r, duty_g, duty_b;
  logic [7:0]    pend_r, pend_g, pend_b;
  logic          pend_full;
  logic          tick, boundary, handshake;

  // Active-low LED level for one channel; off whenever disabled.
  function automatic logic led_level(input logic ena, input logic [7:0] cnt,
                                     input logic [7:0] duty);
    return ~(ena && (cnt < duty));
  endfunction

  assign tick      = (presc == PRESC_MAX);
  assign boundary  = tick && (pwm_cnt == 8'd255);
  assign in_ready  = !pend_full && !rst;
  assign handshake = in_valid && in_ready;

  // Timebase: prescaler feeding the free-running 8-bit PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= 8'd0;
    end else begin
      if (tick) begin
        presc   <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        presc   <= presc + PW'(1);
      end
    end
  end

  // Pending buffer and active duties; a handshake needs pend_full=0, so it
  // can never collide with a transfer and lands in pending even on a boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full <= 1'b0;
      pend_r    <= 8'd0;
      pend_g    <= 8'd0;
      pend_b    <= 8'd0;
      duty_r    <= 8'd0;
      duty_g    <= 8'd0;
      duty_b    <= 8'd0;
    end else if (boundary && pend_full) begin
      duty_r    <= pend_r;
      duty_g    <= pend_g;
      duty_b    <= pend_b;
      pend_full <= 1'b0;
    end else if (handshake) begin
      pend_r    <= in_r;
      pend_g    <= in_g;
      pend_b    <= in_b;
      pend_full <= 1'b1;
    end
  end

  // Registered outputs: period marker and LED channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_start <= 1'b0;
      RGB_R        <= 1'b1;
      RGB_G        <= 1'b1;
      RGB_B        <= 1'b1;
    end else begin
      period_start <= boundary;
      RGB_R        <= led_level(en, pwm_cnt, duty_r);
      RGB_G        <= led_level(en, pwm_cnt, duty_g);
      RGB_B        <= led_level(en, pwm_cnt, duty_b);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver at PRESCALE=2: time-index model checked every cycle
// plus directed scenarios with hand-computed low-time counts and timings.
module tb_rgb_pwm_driver;

  localparam int P      = 2;
  localparam int PERIOD = 256 * P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_r = 8'd0, in_g = 8'd0, in_b = 8'd0;
  logic       in_ready, period_start, RGB_R, RGB_G, RGB_B;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel = 0;

  rgb_pwm_driver #(.PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .period_start(period_start),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
  );

  always #5 clk = ~clk;

  // Model: position in period comes straight from cycles since reset.
  logic       m_ok = 1'b0;
  int         m_k = 0;
  logic       m_pf = 1'b0;
  logic [7:0] m_pr, m_pg, m_pb;
  logic [7:0] m_dr = 8'd0, m_dg = 8'd0, m_db = 8'd0;
  logic       exp_r = 1'b1, exp_g = 1'b1, exp_b = 1'b1, exp_ps = 1'b0;

  function automatic int pwm_of(input int k);
    return (k % PERIOD) / P;
  endfunction

  function automatic bit bnd_of(input int k);
    return (k % PERIOD) == PERIOD - 1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_ok   <= 1'b1;
      m_k    <= 0;
      m_pf   <= 1'b0;
      m_dr   <= 8'd0;
      m_dg   <= 8'd0;
      m_db   <= 8'd0;
      exp_r  <= 1'b1;
      exp_g  <= 1'b1;
      exp_b  <= 1'b1;
      exp_ps <= 1'b0;
    end else if (m_ok) begin
      exp_r  <= !(en && pwm_of(m_k) < int'(m_dr));
      exp_g  <= !(en && pwm_of(m_k) < int'(m_dg));
      exp_b  <= !(en && pwm_of(m_k) < int'(m_db));
      exp_ps <= bnd_of(m_k);
      if (bnd_of(m_k) && m_pf) begin
        m_dr <= m_pr;
        m_dg <= m_pg;
        m_db <= m_pb;
        m_pf <= 1'b0;
      end
      if (in_valid && !m_pf) begin
        m_pr <= in_r;
        m_pg <= in_g;
        m_pb <= in_b;
        m_pf <= 1'b1;
      end
      m_k <= m_k + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_pf && !rst)});
        chk("period_start", {31'd0, period_start}, {31'd0, exp_ps});
        chk("rgb_r", {31'd0, RGB_R}, {31'd0, exp_r});
        chk("rgb_g", {31'd0, RGB_G}, {31'd0, exp_g});
        chk("rgb_b", {31'd0, RGB_B}, {31'd0, exp_b});
      end
    end
  end

  task automatic wait_ps(input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ps_seen", {31'd0, ok}, 32'd1);
  endtask

  // Counts low clocks per channel over the 512 cycles following a period_start.
  task automatic count_period(input bit drop, input int er, input int eg, input int eb,
                              input string tag);
    int lr = 0;
    int lg = 0;
    int lb = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (drop && i == 0) begin
        chk({tag, "_next_pending"}, {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
      end
      if (RGB_R === 1'b0) lr++;
      if (RGB_G === 1'b0) lg++;
      if (RGB_B === 1'b0) lb++;
    end
    chk({tag, "_r_low"}, lr, er);
    chk({tag, "_g_low"}, lg, eg);
    chk({tag, "_b_low"}, lb, eb);
  endtask

  initial begin
    bit ok;
    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_rgb", {29'd0, RGB_R, RGB_G, RGB_B}, 32'd7);
      chk("rst_ps", {31'd0, period_start}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
    end
    rst = 1'b0;
    rel = cyc;
    en = 1'b1;
    in_valid = 1'b1;
    in_r = 8'd64; in_g = 8'd0; in_b = 8'd255;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_r = 8'hAA; in_g = 8'h55; in_b = 8'h0F;
    chk("basic_pending", {31'd0, in_ready}, 32'd0);
    wait_ps(600);
    chk("first_ps_delay", cyc - rel, 32'd512);
    count_period(1'b0, 128, 0, 510, "basic");

    // Backpressure: A accepted, B held until A transfers.
    in_valid = 1'b1;
    in_r = 8'd32; in_g = 8'd16; in_b = 8'd8;
    @(posedge clk);
    #1;
    in_r = 8'd200; in_g = 8'd1; in_b = 8'd100;
    chk("a_pending", {31'd0, in_ready}, 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_ready_back", {31'd0, ok}, 32'd1);
    chk("bp_ready_on_ps", {31'd0, period_start}, 32'd1);
    count_period(1'b1, 64, 32, 16, "a");
    count_period(1'b0, 400, 2, 200, "b");

    // Handshake exactly on the boundary cycle.
    repeat (511) @(negedge clk);
    in_valid = 1'b1;
    in_r = 8'd128; in_g = 8'd255; in_b = 8'd0;
    @(negedge clk);
    chk("sim_ps", {31'd0, period_start}, 32'd1);
    in_valid = 1'b0;
    count_period(1'b0, 400, 2, 200, "sim_old");
    count_period(1'b0, 256, 510, 0, "sim_new");

    // Enable drop and resume mid-period (duty r=128).
    repeat (100) @(negedge clk);
    chk("en_on_low", {31'd0, RGB_R}, 32'd0);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_r", {31'd0, RGB_R}, 32'd1);
    chk("en_off_g", {31'd0, RGB_G}, 32'd1);
    repeat (20) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("en_resume_low", {31'd0, RGB_R}, 32'd0);
    repeat (134) @(negedge clk);
    chk("en_cnt127_low", {31'd0, RGB_R}, 32'd0);
    @(negedge clk);
    chk("en_cnt128_high", {31'd0, RGB_R}, 32'd1);

    // Reset with a word pending.
    in_valid = 1'b1;
    in_r = 8'd10; in_g = 8'd20; in_b = 8'd30;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("d_pending", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_rgb", {29'd0, RGB_R, RGB_G, RGB_B}, 32'd7);
    rst = 1'b0;
    rel = cyc;
    @(negedge clk);
    chk("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);
    wait_ps(600);
    chk("mid_rst_ps_delay", cyc - rel, 32'd512);
    count_period(1'b0, 0, 0, 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
